// File: rtl/seq_mult_shift_add_if.sv
// Start/done handshake bundle for seq_mult_shift_add.
// SEQ_MULT_OVF_EN adds the registered ovf flag.
interface seq_mult_shift_add_if #(
    parameter int unsigned N = 8
) ();
    logic             start;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;
`ifdef SEQ_MULT_OVF_EN
    logic             ovf;

    modport master (output start, output a, output b,
                    input busy, input done, input product, input ovf);
    modport slave  (input start, input a, input b,
                    output busy, output done, output product, output ovf);
`else
    modport master (output start, output a, output b,
                    input busy, input done, input product);
    modport slave  (input start, input a, input b,
                    output busy, output done, output product);
`endif
endinterface

// File: rtl/full_adder_nbit_behavioral.sv
// N-bit behavioural ripple adder: {cout, sum} = a + b + cin.
module full_adder_nbit_behavioral #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};
endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential unsigned N x N shift-and-add multiplier, one add-and-shift step per clock.
// Optional macro SEQ_MULT_OVF_EN adds ovf = result does not fit in N bits.
module seq_mult_shift_add #(
    parameter int unsigned N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_mult_shift_add_if.slave   bus
);
    localparam int unsigned CntW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q;
    logic [N-1:0]    m_q;
    logic [N-1:0]    q_q;
    logic [N-1:0]    acc_q;
    logic [CntW-1:0] cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [2*N-1:0]  product_q;
`ifdef SEQ_MULT_OVF_EN
    logic            ovf_q;
`endif

    logic [N-1:0]    add_b;
    logic [N-1:0]    sum;
    logic            cout;
    logic [N-1:0]    acc_d;
    logic [N-1:0]    q_d;

    full_adder_nbit_behavioral #(
        .N (N)
    ) u_adder (
        .a_i    (acc_q),
        .b_i    (add_b),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // Carry drops into the top of ACC, ACC LSB drops into the top of Q.
    always_comb begin
        add_b        = q_q[0] ? m_q : '0;
        {acc_d, q_d} = (2 * N)'({cout, sum, q_q} >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            m_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
`ifdef SEQ_MULT_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        m_q     <= bus.a;
                        q_q     <= bus.b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(N - 1)) begin
                        state_q   <= StDone;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        product_q <= {acc_d, q_d};
`ifdef SEQ_MULT_OVF_EN
                        ovf_q     <= |acc_d;
`endif
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
`ifdef SEQ_MULT_OVF_EN
    assign bus.ovf     = ovf_q;
`endif
endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Scoreboard bench for seq_mult_shift_add: directed N=8 vectors plus a full N=4 sweep.
module tb_seq_mult_shift_add;
    localparam int unsigned N  = 8;
    localparam int unsigned N4 = 4;

    typedef struct {
        logic [15:0] p;
        int unsigned c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_mult_shift_add_if #(.N(N))  bus  ();
    seq_mult_shift_add_if #(.N(N4)) bus4 ();

    seq_mult_shift_add #(.N(N)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    seq_mult_shift_add #(.N(N4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int unsigned cyc    = 0;
    exp_t        q8[$];
    logic [7:0]  q4[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Scoreboard monitors: pop on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("busy_done_excl", {63'd0, bus.busy & bus.done}, 64'd0);
            if (bus.done) begin
                if (q8.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    e = q8.pop_front();
                    check("product", {48'd0, bus.product}, {48'd0, e.p});
                    check("latency", {32'd0, cyc}, {32'd0, e.c});
`ifdef SEQ_MULT_OVF_EN
                    check("ovf", {63'd0, bus.ovf}, {63'd0, |e.p[15:8]});
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] p;
        if (!rst && bus4.done) begin
            if (q4.size() == 0) begin
                flag("unexpected_done4");
            end else begin
                p = q4.pop_front();
                check("product4", {56'd0, bus4.product}, {56'd0, p});
`ifdef SEQ_MULT_OVF_EN
                check("ovf4", {63'd0, bus4.ovf}, {63'd0, |p[7:4]});
`endif
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!bus.busy && !bus.done) return;
        end
        flag("wait_idle_timeout");
    endtask

    task automatic wait_idle4();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!bus4.busy && !bus4.done) return;
        end
        flag("wait_idle4_timeout");
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit push,
                         output int unsigned c0);
        wait_idle();
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        c0 = cyc;
        check("accept_busy", {63'd0, bus.busy}, 64'd1);
        if (push) q8.push_back('{p: 16'(a) * 16'(b), c: c0 + N});
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b);
        wait_idle4();
        bus4.start = 1'b1;
        bus4.a     = a;
        bus4.b     = b;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        q4.push_back(8'(a) * 8'(b));
    endtask

    initial begin
        int unsigned c1, c2, c3;
        bit seen;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_product", {48'd0, bus.product}, 64'd0);
        rst = 1'b0;

        // 13*11=0x8F, 255*255=0xFE01, zero operands on either side
        issue(8'd13, 8'd11, 1'b1, c1);
        issue(8'd255, 8'd255, 1'b1, c1);
        issue(8'd0, 8'd200, 1'b1, c1);
        issue(8'd77, 8'd0, 1'b1, c1);

        // start held through CALC and DONE with changed operands
        wait_idle();
        bus.start = 1'b1;
        bus.a     = 8'd6;
        bus.b     = 8'd7;
        @(posedge clk);
        #1;
        c1 = cyc;
        q8.push_back('{p: 16'd42, c: c1 + N});
        bus.a = 8'd100;
        bus.b = 8'd3;
        seen  = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy && bus.done == 1'b0 && cyc > c1 + N) seen = 1'b1;
        end
        if (!seen) flag("reaccept_timeout");
        c2 = cyc;
        bus.start = 1'b0;
        q8.push_back('{p: 16'd300, c: c2 + N});
        check("reaccept_gap", {32'd0, c2 - c1}, {32'd0, N + 2});

        // abort after 3 CALC steps
        issue(8'd5, 8'd5, 1'b0, c1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_done", {63'd0, bus.done}, 64'd0);
        check("abort_product", {48'd0, bus.product}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        issue(8'd9, 8'd9, 1'b1, c1);
        issue(8'd200, 8'd3, 1'b1, c2);
        issue(8'd17, 8'd15, 1'b1, c3);
        check("b2b_gap", {32'd0, c3 - c2}, {32'd0, N + 2});

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue4(4'(a), 4'(b));
            end
        end

        for (int k = 0; k < 100 && (q8.size() != 0 || q4.size() != 0); k++) @(negedge clk);
        if (q8.size() != 0) flag("drain_q8");
        if (q4.size() != 0) flag("drain_q4");
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
